// File: rtl/alu_pkg.sv
// Shared constants for the pipelined carry-lookahead adder: operation mode
// encoding, default geometry and the effective carry-in rule.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_GROUP = 8;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Subtraction is A + ~B + 1, so the external carry-in only matters for adds.
  function automatic logic eff_carry_in(input logic sub, input logic c_i);
    return (sub == MODE_SUB) ? 1'b1 : c_i;
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead block: group propagate/generate plus the group
// sum for a fixed carry-in.
module cla_group
  import alu_pkg::*;
#(
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             cin,
  output logic             grp_p,
  output logic             grp_g,
  output logic [GROUP-1:0] s
);

  logic [GROUP:0] carry;
  logic [GROUP:0] gen_chain;

  // The recurrences are unrolled, so each carry becomes a flat lookahead term.
  always_comb begin
    carry        = '0;
    gen_chain    = '0;
    carry[0]     = cin;
    gen_chain[0] = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      carry[i+1]     = g[i] | (p[i] & carry[i]);
      gen_chain[i+1] = g[i] | (p[i] & gen_chain[i]);
    end
  end

  assign s     = p ^ carry[GROUP-1:0];
  assign grp_p = &p;
  assign grp_g = gen_chain[GROUP];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-select/lookahead adder-subtractor with valid/ready flow
// control. S1 holds per-group P/G and both candidate sums; S2 holds the result.
module pipelined_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_i,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_o,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH < 8) || (WIDTH > 64) || (GROUP < 1) || ((WIDTH % GROUP) != 0)) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be 8..64 and a multiple of GROUP");
  end

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] sum0_c;
  logic [WIDTH-1:0] sum1_c;
  logic [NG-1:0]    grp_p_c;
  logic [NG-1:0]    grp_g_c;
  logic [NG-1:0]    unused_grp_p1;
  logic [NG-1:0]    unused_grp_g1;
  logic             cin_eff;

  assign b_eff   = (sub == MODE_ADD) ? b : ~b;
  assign cin_eff = eff_carry_in(sub, c_i);
  assign p_bit   = a ^ b_eff;
  assign g_bit   = a & b_eff;

  // Each group computes its sum for both possible carry-ins; S2 only selects.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_cin0 (
      .p     (p_bit[gi*GROUP +: GROUP]),
      .g     (g_bit[gi*GROUP +: GROUP]),
      .cin   (1'b0),
      .grp_p (grp_p_c[gi]),
      .grp_g (grp_g_c[gi]),
      .s     (sum0_c[gi*GROUP +: GROUP])
    );
    cla_group #(.GROUP(GROUP)) u_cin1 (
      .p     (p_bit[gi*GROUP +: GROUP]),
      .g     (g_bit[gi*GROUP +: GROUP]),
      .cin   (1'b1),
      .grp_p (unused_grp_p1[gi]),
      .grp_g (unused_grp_g1[gi]),
      .s     (sum1_c[gi*GROUP +: GROUP])
    );
  end

  logic s1_full;
  logic s2_full;
  logic s1_adv;
  logic in_fire;
  logic s2_load;

  assign s1_adv    = !s2_full || out_ready;
  assign in_ready  = !s1_full || s1_adv;
  assign in_fire   = in_valid && in_ready;
  assign s2_load   = s1_full && s1_adv;
  assign out_valid = s2_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_full <= 1'b0;
      s2_full <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_full <= 1'b1;
      end else if (s1_adv) begin
        s1_full <= 1'b0;
      end
      if (s1_adv) begin
        s2_full <= s1_full;
      end
    end
  end

  logic [NG-1:0]    s1_grp_p;
  logic [NG-1:0]    s1_grp_g;
  logic [WIDTH-1:0] s1_sum0;
  logic [WIDTH-1:0] s1_sum1;
  logic             s1_cin;
  logic             s1_msb_p;

  // S1 payload is qualified by s1_full, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_grp_p <= grp_p_c;
      s1_grp_g <= grp_g_c;
      s1_sum0  <= sum0_c;
      s1_sum1  <= sum1_c;
      s1_cin   <= cin_eff;
      s1_msb_p <= p_bit[WIDTH-1];
    end
  end

  logic [NG:0]      gcarry;
  logic [WIDTH-1:0] sum_next;
  logic             c_o_next;
  logic             ovf_next;
  logic             zero_next;

  always_comb begin
    gcarry    = '0;
    sum_next  = '0;
    gcarry[0] = s1_cin;
    for (int k = 0; k < NG; k++) begin
      gcarry[k+1] = s1_grp_g[k] | (s1_grp_p[k] & gcarry[k]);
      sum_next[k*GROUP +: GROUP] = gcarry[k] ? s1_sum1[k*GROUP +: GROUP]
                                             : s1_sum0[k*GROUP +: GROUP];
    end
  end

  // Carry into the MSB is recovered from its propagate bit and its sum bit.
  assign c_o_next  = gcarry[NG];
  assign ovf_next  = (s1_msb_p ^ sum_next[WIDTH-1]) ^ gcarry[NG];
  assign zero_next = (sum_next == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      c_o  <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (s2_load) begin
      sum  <= sum_next;
      c_o  <= c_o_next;
      ovf  <= ovf_next;
      zero <= zero_next;
    end
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal values 8..64.
REQ-002 Parameter: GROUP, 8, lookahead group size in bits; WIDTH SHALL be an integer multiple of GROUP (elaboration error otherwise).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operands valid this cycle.
REQ-006 Port: in_ready  output  1  block can accept operands this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: c_i  input  1  carry-in; ignored when sub=1.
REQ-010 Port: sub  input  1  0 = A+B+c_i, 1 = A-B (A + ~B + 1).
REQ-011 Port: out_valid  output  1  result valid.
REQ-012 Port: out_ready  input  1  downstream accepts result.
REQ-013 Port: sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 Port: c_o  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 Port: ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-016 Port: zero  output  1  sum == 0.

Function
REQ-017 Input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; output transfer on out_valid=1 and out_ready=1.
REQ-018 Two pipeline stages: S1 registers per-group P, G and group sums for both group carry-in values (0 and 1); S2 registers the final result.
REQ-019 S1 SHALL compute per-bit p=a^b', g=a&b', with b'=b^{WIDTH{sub}} and effective carry-in cin=sub?1:c_i, registered with the op.
REQ-020 S2 SHALL derive group carries by lookahead across groups from registered group P/G and cin (Cg_k = G_k | P_k & Cg_(k-1)), and select each group's precomputed sum by its carry-in.
REQ-021 Latency: a transfer accepted in cycle N SHALL appear on outputs with out_valid=1 in cycle N+2 when out_ready stays 1.
REQ-022 Throughput: one operation per cycle sustained while out_ready=1.
REQ-023 Backpressure: each stage holds its contents while its successor is full and not draining; in_ready = !S1_full | (S1 advances this cycle); S1 advances when !S2_full | out_ready.
REQ-024 in_ready SHALL be combinational from out_ready and stage-full flags only, never from in_valid.
REQ-025 Simultaneous output transfer and new input with full pipeline SHALL advance all stages in one cycle without loss or duplication.
REQ-026 sum, c_o, ovf, zero SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 Wrap-around: 0xFFFFFFFF+1 (WIDTH=32) yields sum=0, c_o=1, zero=1, ovf=0.
REQ-028 Data registers without valid SHALL NOT propagate to outputs as valid; payload when out_valid=0 is don't-care.

Reset
REQ-029 On rst=1, S1_full and S2_full SHALL clear immediately (asynchronously); out_valid=0, in_ready=1 after release.
REQ-030 On reset, sum=0, c_o=0, ovf=0, zero=0.
REQ-031 Reset mid-operation SHALL discard all in-flight operations; no result emerges for them after release.
REQ-032 First transfer is accepted on the first rising edge with rst=0.

Structure
REQ-033 Shared package alu_pkg SHALL hold the sub/add mode encoding constants and default WIDTH/GROUP values.
REQ-034 One sub-module cla_group SHALL implement a GROUP-bit lookahead producing group P, group G and the sum for a given carry-in; instantiated twice per group (cin 0/1) in S1.
REQ-035 Inter-group lookahead and handshake logic reside in pipelined_cla_adder.

Verification
REQ-036 Single add: a=0x0000_00FF, b=0x0000_0001, c_i=0, sub=0 -> two cycles later sum=0x0000_0100, c_o=0, ovf=0, zero=0.
REQ-037 Subtract: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, c_o=0, ovf=0; a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1, c_o=1.
REQ-038 Full group-to-group ripple: a=0xFFFF_FFFF, b=0, c_i=1 -> sum=0, c_o=1, zero=1; and a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1.
REQ-039 Backpressure: stream 4 ops back-to-back, hold out_ready=0 for 3 cycles after first out_valid -> in_ready drops after 2 held, all 4 results emerge in order, none lost/duplicated.
REQ-040 Reset mid-flight: accept 2 ops, assert rst asynchronously between edges -> out_valid=0 immediately, no stale result after release; next op returns correct result at latency 2.
REQ-041 Random regression: 10k random a/b/c_i/sub with random out_ready for WIDTH=32/GROUP=8 and WIDTH=16/GROUP=4 vs. reference model of {c_o,sum}=a+b'+cin.
